// File: rtl/alu_rr_sched.sv
// ---------------------------------------------------------------------------
// alu_rr_sched
//   Round-robin scheduler that shares one external combinational ALU
//   (aluc 00 AND, 01 OR, 10 ADD, 11 SUB) among NREQ requesters.
//   The scheduler grants one request, registers its operands, and drives the
//   ALU from those registers for one EXEC cycle. It then captures the result
//   together with the requester tag and holds it until the consumer takes it.
//
// Handshakes (valid/ready):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A producer keeps valid and its payload stable until it sees ready.
//   Ready may depend combinationally on valid. Every ready/valid below
//   follows this rule: each req channel i, and the single rsp channel.
//
// Ports:
//   clk, clrn            clock, asynchronous active-low clear
//   req_valid/req_ready  per-requester request handshake (ready one-hot/zero)
//   req_a/req_b/req_aluc packed operands; requester i at [i*WIDTH +: WIDTH]
//                        and [i*2 +: 2]
//   alu_a/alu_b/alu_aluc registered operands driven to the shared ALU
//   alu_s                combinational result coming back from the ALU
//   rsp_valid/rsp_ready  response handshake
//   rsp_id/rsp_s         owning requester and the result
//   rsp_zero             result==0 flag (only with ALU_RR_SCHED_ZERO_EN)
//   dbg_state            current FSM state, for observation only
//
// Optional feature: define ALU_RR_SCHED_ZERO_EN to add the rsp_zero output.
// ---------------------------------------------------------------------------
module alu_rr_sched #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  clrn,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*2-1:0]     req_aluc,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   output logic [1:0]            alu_aluc,
   input  logic [WIDTH-1:0]      alu_s,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_s,
`ifdef ALU_RR_SCHED_ZERO_EN
   output logic                  rsp_zero,
`endif
   output logic [1:0]            dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]     state;
   logic [IDW-1:0] last;   // most recently granted requester
   logic [IDW-1:0] tag;    // owner of the operation in flight
   logic [IDW-1:0] win;
   logic           found;
   logic           grant;
   int             idx;

   assign dbg_state = state;

   // Scan last+1, last+2, ... (mod NREQ). The first requester found with
   // valid set wins, so the last winner always goes to the back of the line.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
   end

   // A new operation may start when the pipe is empty, or when the held
   // response leaves in this same cycle. clrn gates ready so that nothing is
   // accepted while the block is held in reset.
   assign grant = clrn && found &&
                  ((state == S_IDLE) || ((state == S_RESP) && rsp_ready));

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[win] = 1'b1;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state     <= S_IDLE;
         last      <= IDW'(NREQ - 1);
         tag       <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_aluc  <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_s     <= '0;
`ifdef ALU_RR_SCHED_ZERO_EN
         rsp_zero  <= 1'b0;
`endif
      end else begin
         // Any grant, from IDLE or from RESP, loads the operand registers.
         if (grant) begin
            alu_a    <= req_a[win*WIDTH +: WIDTH];
            alu_b    <= req_b[win*WIDTH +: WIDTH];
            alu_aluc <= req_aluc[win*2 +: 2];
            tag      <= win;
            last     <= win;
         end
         case (state)
            S_IDLE: begin
               if (grant) state <= S_EXEC;
            end
            S_EXEC: begin
               rsp_s     <= alu_s;
               rsp_id    <= tag;
               rsp_valid <= 1'b1;
`ifdef ALU_RR_SCHED_ZERO_EN
               rsp_zero  <= (alu_s == '0);
`endif
               state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= grant ? S_EXEC : S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
